bayer_demosaic: RTL and testbench
=================================

// Module: bayer_demosaic
// PURPOSE
//  Streaming Bayer-to-RGB converter between the sensor capture block and the frame store.
//  Builds a 2x2 window from the current line and a one-line-delayed copy, then outputs
//  R, G, B per window. G is the truncated mean of the window's two green sites.
//  Adds over the fixed converter: parametrised width/line length, runtime CFA pattern,
//  full-resolution mode, and internal x/y tracking from a start-of-frame pulse.
// PARAMETERS
//  DW       10    raw and per-channel output pixel width
//  ACTIVE_W 1280  pixels per line; must be even and >= 4
//  XW       11    x counter width; 2**XW >= ACTIVE_W
// PORTS
//  iCLK     in   1   pixel clock
//  iRST     in   1   asynchronous, active-low reset
//  iSOF     in   1   start-of-frame pulse; qualifies the first pixel if iDVAL is high in the same cycle
//  iDVAL    in   1   raw pixel valid
//  iDATA    in   DW  raw pixel
//  iPATTERN in   2   CFA phase: 0=RGGB 1=GRBG 2=GBRG 3=BGGR
//  iMODE    in   1   0 = 2x2 binning (quarter resolution), 1 = full resolution
//  oRed     out  DW  red
//  oGreen   out  DW  green = (G_a + G_b) >> 1
//  oBlue    out  DW  blue
//  oDVAL    out  1   output valid, one-cycle strobe per output pixel
//  oX       out  XW  x of the window's bottom-right pixel
//  oSOL     out  1   high with the first output pixel of each output line
// BEHAVIOUR
//  - Reset: all outputs 0; x=0, y_odd=0, y_nz=0 (y_nz = current y != 0); pattern/mode regs = 0.
//    Line buffer RAM is not cleared.
//  - Reset leaves the block in the same state as a received iSOF.
//  - Config: iPATTERN and iMODE are latched only on iSOF (any iDVAL); mid-frame changes ignored.
//  - Accepted pixel = iDVAL high. Counters advance only on accepted pixels.
//    x wraps at ACTIVE_W-1 -> 0; on wrap y_odd toggles and y_nz is set.
//  - iSOF forces x=0, y_odd=0, y_nz=0 before the same-cycle pixel is counted.
//    That pixel is therefore (0,0); a short previous frame is simply abandoned.
//  - Window per accepted pixel (x,y): BR=iDATA, BL=previous current-line pixel,
//    TR=line-buffer output (x,y-1), TL=its one-sample delay.
//  - Window valid = y_nz && x!=0. No edge padding.
//  - Emit condition:
//    . mode 1: every valid window, giving (ACTIVE_W-1) x (H-1) output pixels.
//    . mode 0: valid windows with x odd and y odd only.
//  - Phase e = {y_odd_of_TL ^ PAT[1], x_odd_of_TL ^ PAT[0]}, where TL = (x-1, y-1):
//    . e=00  R=TL  G=TR+BL  B=BR
//    . e=01  R=TR  G=TL+BR  B=BL
//    . e=10  R=BL  G=TL+BR  B=TR
//    . e=11  R=BR  G=TR+BL  B=TL
//  - Green sum is DW+1 bits; oGreen = sum[DW:1]. Truncate, no rounding, no overflow possible.
//  - Latency: outputs registered 1 cycle after the accepted BR pixel.
//    oDVAL is a single-cycle pulse; outputs hold their values when oDVAL=0.
//  - iDVAL gaps: no effect on the window; line buffer and delay regs shift only on accepted pixels.
//  - No back-pressure; the downstream consumer accepts every oDVAL.
//  - oSOL asserts on the first emitted pixel after each x wrap (x=1 in mode 1, x=1 in mode 0).
// STRUCTURE
//  - Shared package: CFA_RGGB/GRBG/GBRG/BGGR localparam codes; MODE_BIN/MODE_FULL.
//  - Sub-module bayer_line_buf: DEPTH=ACTIVE_W, WIDTH=DW single-line delay with shift enable.
//    Inferred simple dual-port RAM plus read/write address counter, 1-cycle read.
//  - Top level: counters, config latch, window registers, phase mux, output register.
// TESTING
//  1. RGGB, mode 0, ACTIVE_W=4, rows 0:{100,200,101,201} and 1:{300,400,301,401}
//     -> two pulses: (R100,G250,B400) then (R101,G251,B401).
//  2. Same data, iPATTERN=3 latched on iSOF
//     -> first pulse R400, G250, B100; pattern change mid-frame has no effect.
//  3. Mode 1, 4x3 frame of a constant 512 -> exactly 6 oDVAL pulses, all channels 512;
//     oSOL on the 1st and 4th pulses.
//  4. Max green, DW=10: both G sites = 1023 -> oGreen=1023. G sites 1023 and 0 -> oGreen=511.
//  5. Random iDVAL gaps (50% duty) vs gap-free run of the same data
//     -> identical output pixel sequence; each oDVAL exactly 1 cycle after its accepted BR pixel.
//  6. iRST low mid-line, then iSOF with iDVAL and new frame
//     -> outputs 0 during reset, no pulses from the first line, new frame output correct.

Source files
------------

// File: rtl/bayer_demosaic_pkg.sv
// Shared codes for the Bayer demosaic block: CFA phases, output modes, window phase select.
package bayer_demosaic_pkg;

  localparam logic [1:0] CFA_RGGB = 2'd0;
  localparam logic [1:0] CFA_GRBG = 2'd1;
  localparam logic [1:0] CFA_GBRG = 2'd2;
  localparam logic [1:0] CFA_BGGR = 2'd3;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_FULL = 1'b1;

  // Names say which window corner carries red; blue is always the diagonal opposite.
  typedef enum logic [1:0] {
    PH_TL_RED = 2'b00,
    PH_TR_RED = 2'b01,
    PH_BL_RED = 2'b10,
    PH_BR_RED = 2'b11
  } phase_e;

endpackage

// File: rtl/bayer_demosaic_if.sv
// Pixel stream bus: raw Bayer in with frame config, RGB out with position/line markers.
interface bayer_demosaic_if #(
  parameter int DW = 10,
  parameter int XW = 11
);
  logic          iSOF;
  logic          iDVAL;
  logic [DW-1:0] iDATA;
  logic [1:0]    iPATTERN;
  logic          iMODE;
  logic [DW-1:0] oRed;
  logic [DW-1:0] oGreen;
  logic [DW-1:0] oBlue;
  logic          oDVAL;
  logic [XW-1:0] oX;
  logic          oSOL;

  modport slave (
    input  iSOF, iDVAL, iDATA, iPATTERN, iMODE,
    output oRed, oGreen, oBlue, oDVAL, oX, oSOL
  );

  modport master (
    output iSOF, iDVAL, iDATA, iPATTERN, iMODE,
    input  oRed, oGreen, oBlue, oDVAL, oX, oSOL
  );
endinterface

// File: rtl/bayer_line_buf.sv
// One-line delay of DEPTH accepted samples: simple dual-port RAM with a circular pointer.
module bayer_line_buf #(
  parameter int DEPTH = 1280,
  parameter int WIDTH = 10
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d, rd_addr;
  logic [WIDTH-1:0] rd_q;

  // Prefetch the slot that the next accepted sample will overwrite, so its old
  // contents are ready in the same cycle as that sample.
  always_comb begin
    ptr_d   = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    rd_addr = en_i ? ptr_d : ptr_q;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST)     ptr_q <= '0;
    else if (en_i) ptr_q <= ptr_d;
  end

  always_ff @(posedge iCLK) begin
    if (en_i) mem[ptr_q] <= din_i;
    rd_q <= mem[rd_addr];
  end

  assign dout_o = rd_q;

endmodule

// File: rtl/bayer_demosaic.sv
// Streaming Bayer-to-RGB: 2x2 window from current line plus line buffer, phase mux,
// binned or full-resolution output, registered one cycle after the bottom-right pixel.
module bayer_demosaic
  import bayer_demosaic_pkg::*;
#(
  parameter int DW       = 10,
  parameter int ACTIVE_W = 1280,
  parameter int XW       = 11
) (
  input  logic             iCLK,
  input  logic             iRST,
  bayer_demosaic_if.slave  bus
);
  logic          acc;
  logic [XW-1:0] x_q, x_d, x_cur;
  logic          y_odd_q, y_odd_d, y_odd_cur;
  logic          y_nz_q, y_nz_d, y_nz_cur;
  logic [1:0]    pat_q, pat_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] bl_q, bl_d, tl_q, tl_d, tr;
  logic          wrap, emit;
  phase_e        phase;
  logic [DW-1:0] r_sel, b_sel, g_a, g_b;
  logic [DW:0]   gsum;
  logic [DW-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic          dval_q, dval_d, sol_q, sol_d;
  logic [XW-1:0] ox_q, ox_d;

  assign acc = bus.iDVAL;

  bayer_line_buf #(.DEPTH(ACTIVE_W), .WIDTH(DW)) u_line_buf (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .en_i   (acc),
    .din_i  (bus.iDATA),
    .dout_o (tr)
  );

  // iSOF clears the position before the same-cycle pixel is counted.
  always_comb begin
    x_cur     = bus.iSOF ? '0   : x_q;
    y_odd_cur = bus.iSOF ? 1'b0 : y_odd_q;
    y_nz_cur  = bus.iSOF ? 1'b0 : y_nz_q;
    pat_d     = bus.iSOF ? bus.iPATTERN : pat_q;
    mode_d    = bus.iSOF ? bus.iMODE    : mode_q;
    wrap      = (x_cur == XW'(ACTIVE_W - 1));
    x_d       = x_cur;
    y_odd_d   = y_odd_cur;
    y_nz_d    = y_nz_cur;
    bl_d      = bl_q;
    tl_d      = tl_q;
    if (acc) begin
      x_d     = wrap ? '0 : x_cur + 1'b1;
      y_odd_d = y_odd_cur ^ wrap;
      y_nz_d  = y_nz_cur | wrap;
      bl_d    = bus.iDATA;
      tl_d    = tr;
    end
  end

  // Phase is taken at the top-left site, which sits at (x-1, y-1).
  always_comb begin
    phase = phase_e'({~y_odd_cur ^ pat_q[1], ~x_cur[0] ^ pat_q[0]});
    r_sel = tl_q;
    b_sel = bus.iDATA;
    g_a   = tr;
    g_b   = bl_q;
    unique case (phase)
      PH_TL_RED: begin r_sel = tl_q;      b_sel = bus.iDATA; g_a = tr;   g_b = bl_q;      end
      PH_TR_RED: begin r_sel = tr;        b_sel = bl_q;      g_a = tl_q; g_b = bus.iDATA; end
      PH_BL_RED: begin r_sel = bl_q;      b_sel = tr;        g_a = tl_q; g_b = bus.iDATA; end
      PH_BR_RED: begin r_sel = bus.iDATA; b_sel = tl_q;      g_a = tr;   g_b = bl_q;      end
    endcase
    gsum = {1'b0, g_a} + {1'b0, g_b};
  end

  always_comb begin
    emit   = acc && y_nz_cur && (x_cur != '0) &&
             ((mode_q == MODE_FULL) || (x_cur[0] && y_odd_cur));
    dval_d = emit;
    sol_d  = emit && (x_cur == XW'(1));
    red_d  = emit ? r_sel       : red_q;
    grn_d  = emit ? gsum[DW:1]  : grn_q;
    blu_d  = emit ? b_sel       : blu_q;
    ox_d   = emit ? x_cur       : ox_q;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      x_q     <= '0;
      y_odd_q <= 1'b0;
      y_nz_q  <= 1'b0;
      pat_q   <= '0;
      mode_q  <= 1'b0;
      bl_q    <= '0;
      tl_q    <= '0;
      red_q   <= '0;
      grn_q   <= '0;
      blu_q   <= '0;
      dval_q  <= 1'b0;
      sol_q   <= 1'b0;
      ox_q    <= '0;
    end else begin
      x_q     <= x_d;
      y_odd_q <= y_odd_d;
      y_nz_q  <= y_nz_d;
      pat_q   <= pat_d;
      mode_q  <= mode_d;
      bl_q    <= bl_d;
      tl_q    <= tl_d;
      red_q   <= red_d;
      grn_q   <= grn_d;
      blu_q   <= blu_d;
      dval_q  <= dval_d;
      sol_q   <= sol_d;
      ox_q    <= ox_d;
    end
  end

  assign bus.oRed   = red_q;
  assign bus.oGreen = grn_q;
  assign bus.oBlue  = blu_q;
  assign bus.oDVAL  = dval_q;
  assign bus.oX     = ox_q;
  assign bus.oSOL   = sol_q;

endmodule

// File: tb/tb_bayer_demosaic.sv
// Bench for bayer_demosaic: directed and random frames against a site-colour reference model.
module tb_bayer_demosaic;
  localparam int DW   = 10;
  localparam int XW   = 3;
  localparam int W    = 4;
  localparam int MAXH = 8;

  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  always #5 iCLK = ~iCLK;

  bayer_demosaic_if #(.DW(DW), .XW(XW)) bus ();

  bayer_demosaic #(.DW(DW), .ACTIVE_W(W), .XW(XW)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  int passed = 0;
  int total  = 0;
  int pix [MAXH][W];
  logic [3*DW-1:0] obs_q [$];
  logic [3*DW-1:0] run_a [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Colour of a sensor site under CFA phase p: 0=R 1=G 2=B (RGGB shifted by p).
  function automatic int site(input int x, input int y, input int p);
    int r, c;
    r = (y % 2) ^ ((p >> 1) & 1);
    c = (x % 2) ^ (p & 1);
    if (r == 0 && c == 0) return 0;
    if (r == 1 && c == 1) return 2;
    return 1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dval"}, 32'(bus.oDVAL), 0);
    chk({tag, "_red"},  32'(bus.oRed),  0);
    chk({tag, "_grn"},  32'(bus.oGreen), 0);
    chk({tag, "_blu"},  32'(bus.oBlue), 0);
    chk({tag, "_x"},    32'(bus.oX),    0);
    chk({tag, "_sol"},  32'(bus.oSOL),  0);
  endtask

  // One clock: drive at negedge, check the registered result just after posedge.
  // Config inputs are scrambled on every non-SOF cycle.
  task automatic cyc(input bit dv, input bit sof, input int d, input int pat, input int mode,
                     input bit e_emit, input int er, input int eg, input int eb,
                     input int ex, input bit esol);
    @(negedge iCLK);
    bus.iDVAL    = dv;
    bus.iSOF     = sof;
    bus.iDATA    = DW'(d);
    bus.iPATTERN = sof ? 2'(pat) : 2'($urandom);
    bus.iMODE    = sof ? 1'(mode) : 1'($urandom);
    @(posedge iCLK);
    #1;
    chk("dval", 32'(bus.oDVAL), 32'(e_emit));
    if (e_emit) begin
      chk("red", 32'(bus.oRed),   er);
      chk("grn", 32'(bus.oGreen), eg);
      chk("blu", 32'(bus.oBlue),  eb);
      chk("x",   32'(bus.oX),     ex);
      chk("sol", 32'(bus.oSOL),   32'(esol));
    end
    if (bus.oDVAL) obs_q.push_back({bus.oRed, bus.oGreen, bus.oBlue});
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, int'($urandom_range(0, 1023)), 0, 0, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  // Streams npix pixels of pix[][] (row-major) with iSOF on the first one.
  task automatic run_frame(input int npix, input int pat, input int mode, input int gap_pct);
    int x, y, r, g, b, v, s;
    bit emit, line_seen;
    obs_q.delete();
    line_seen = 1'b0;
    for (int k = 0; k < npix; k++) begin
      x = k % W;
      y = k / W;
      if (x == 0) line_seen = 1'b0;
      while (int'($urandom_range(0, 99)) < gap_pct) idle();
      emit = (y >= 1) && (x >= 1) && (mode == 1 || ((x % 2 == 1) && (y % 2 == 1)));
      r = 0; g = 0; b = 0;
      if (emit) begin
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++) begin
            v = pix[y-1+dy][x-1+dx];
            s = site(x-1+dx, y-1+dy, pat);
            if (s == 0)      r = v;
            else if (s == 2) b = v;
            else             g += v;
          end
        g = g / 2;
      end
      cyc(1'b1, k == 0, pix[y][x], pat, mode, emit, r, g, b, x, emit && !line_seen);
      if (emit) line_seen = 1'b1;
    end
    idle();
  endtask

  task automatic fill_random(input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < W; x++) pix[y][x] = int'($urandom_range(0, 1023));
  endtask

  logic [3*DW-1:0] e0;
  int pat_r, mode_r;

  initial begin
    bus.iSOF = 1'b0; bus.iDVAL = 1'b0; bus.iDATA = '0; bus.iPATTERN = '0; bus.iMODE = 1'b0;
    #12;
    check_reset_outputs("rst");
    @(negedge iCLK);
    iRST = 1'b1;

    // RGGB binning, directed 4x2 frame
    pix[0] = '{100, 200, 101, 201};
    pix[1] = '{300, 400, 301, 401};
    run_frame(8, 0, 0, 0);
    chk("t1_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("t1_px0", 32'(obs_q[0]), 32'({10'd100, 10'd250, 10'd400}));
      chk("t1_px1", 32'(obs_q[1]), 32'({10'd101, 10'd251, 10'd401}));
    end

    // BGGR latched on iSOF; pattern scrambled afterwards
    run_frame(8, 3, 0, 0);
    chk("t2_count", obs_q.size(), 2);
    if (obs_q.size() >= 1) chk("t2_px0", 32'(obs_q[0]), 32'({10'd400, 10'd250, 10'd100}));

    // full resolution, constant 4x3 frame
    for (int y = 0; y < 3; y++) pix[y] = '{512, 512, 512, 512};
    run_frame(12, 0, 1, 0);
    chk("t3_count", obs_q.size(), 6);
    for (int i = 0; i < obs_q.size(); i++)
      chk("t3_px", 32'(obs_q[i]), 32'({10'd512, 10'd512, 10'd512}));

    // green extremes
    pix[0] = '{5, 1023, 6, 1023};
    pix[1] = '{1023, 7, 1023, 8};
    run_frame(8, 0, 0, 0);
    if (obs_q.size() >= 1) begin
      e0 = obs_q[0];
      chk("t4_gmax", 32'(e0[DW +: DW]), 1023);
    end else chk("t4_gmax_count", obs_q.size(), 1);
    pix[1] = '{0, 7, 0, 8};
    run_frame(8, 0, 0, 0);
    if (obs_q.size() >= 1) begin
      e0 = obs_q[0];
      chk("t4_ghalf", 32'(e0[DW +: DW]), 511);
    end else chk("t4_ghalf_count", obs_q.size(), 1);

    // gap-free vs 50% gaps over identical random data, both modes
    for (int m = 0; m < 2; m++) begin
      fill_random(6);
      pat_r = int'($urandom_range(0, 3));
      run_frame(24, pat_r, m, 0);
      run_a = obs_q;
      run_frame(24, pat_r, m, 50);
      chk("t5_count", obs_q.size(), run_a.size());
      if (obs_q.size() == run_a.size())
        for (int i = 0; i < obs_q.size(); i++) chk("t5_seq", 32'(obs_q[i]), 32'(run_a[i]));
    end

    // abandoned short frame, then a full frame
    fill_random(6);
    run_frame(7, 1, 1, 20);
    fill_random(5);
    pat_r = int'($urandom_range(0, 3));
    mode_r = int'($urandom_range(0, 1));
    run_frame(20, pat_r, mode_r, 25);

    // reset mid-line
    fill_random(3);
    run_frame(6, 2, 1, 0);
    @(negedge iCLK);
    iRST = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge iCLK);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge iCLK);
    iRST = 1'b1;
    fill_random(4);
    run_frame(16, 2, 1, 10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
